// File: rtl/conv_pkg.sv
// Shared types and default geometry for the 3x3 convolution window sequencer.
//   DEF_PIX_W / DEF_IMG_W / DEF_IMG_H : default pixel width and image size
//   DEF_WIN_W                         : width of one packed 3x3 window
//   state_t                           : read-side FSM states
package conv_pkg;

    localparam int unsigned DEF_PIX_W = 8;
    localparam int unsigned DEF_IMG_W = 28;
    localparam int unsigned DEF_IMG_H = 28;
    localparam int unsigned DEF_WIN_W = 9 * DEF_PIX_W;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

endpackage

// File: rtl/line_buffer.sv
// One image line of pixel storage with a single write port and a
// combinational three-pixel read starting at rd_col.
//   clk     : write clock
//   wr_en   : write pixel wr_data at column wr_col
//   wr_col  : write column
//   wr_data : pixel to store
//   rd_col  : leftmost column of the three-pixel read (<= IMG_W-3)
//   rd_data : pixel rd_col+p in bits [p*PIX_W +: PIX_W], p = 0..2
module line_buffer
    import conv_pkg::*;
#(
    parameter  int unsigned IMG_W = DEF_IMG_W,
    parameter  int unsigned PIX_W = DEF_PIX_W,
    localparam int unsigned CW    = $clog2(IMG_W)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [CW-1:0]      wr_col,
    input  logic [PIX_W-1:0]   wr_data,
    input  logic [CW-1:0]      rd_col,
    output logic [3*PIX_W-1:0] rd_data
);

    logic [PIX_W-1:0] mem [IMG_W];

    // Pixel storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_col] <= wr_data;
        end
    end

    // Three adjacent pixels, leftmost in the low bits.
    always_comb begin
        rd_data = '0;
        for (int p = 0; p < 3; p++) begin
            rd_data[p*PIX_W +: PIX_W] = mem[rd_col + CW'(p)];
        end
    end

endmodule

// File: rtl/conv_window_ctrl.sv
// Sequencer in front of the 3x3 conv engine. Raster pixels are written into
// four rotating line buffers; once three full lines are present one row of
// valid (unpadded) 3x3 windows is issued, one window per cycle.
//   i_clk, i_rst    : clock, asynchronous active-high reset
//   i_pixel         : raster-order input pixel
//   i_pixel_valid   : i_pixel valid, taken when o_pixel_ready is high
//   o_pixel_ready   : controller can accept a pixel this cycle
//   o_window        : 3x3 window, byte k = row k/3, col k%3, row 0 on top
//   o_window_valid  : o_window valid
//   o_line_done     : pulse with the last window of an output row
//   o_frame_done    : pulse with the last window of the frame
module conv_window_ctrl
    import conv_pkg::*;
#(
    parameter  int unsigned IMG_W = DEF_IMG_W,
    parameter  int unsigned IMG_H = DEF_IMG_H,
    parameter  int unsigned PIX_W = DEF_PIX_W,
    localparam int unsigned WIN_W = 9 * PIX_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [PIX_W-1:0] i_pixel,
    input  logic             i_pixel_valid,
    output logic             o_pixel_ready,
    output logic [WIN_W-1:0] o_window,
    output logic             o_window_valid,
    output logic             o_line_done,
    output logic             o_frame_done
);

    localparam int unsigned CW    = $clog2(IMG_W);
    localparam int unsigned FW    = $clog2(4 * IMG_W + 1);
    localparam int unsigned LW    = $clog2(IMG_H + 1);
    localparam int unsigned RW    = $clog2(IMG_H - 1);
    localparam int unsigned ROW_W = 3 * PIX_W;

    state_t          state;
    state_t          state_nxt;

    logic [CW-1:0]   wr_col;
    logic [1:0]      wr_sel;
    logic [LW-1:0]   lines_in;
    logic [FW-1:0]   fill;
    logic [FW-1:0]   fill_nxt;
    logic [CW-1:0]   rd_col;
    logic [1:0]      rd_sel;
    logic [1:0]      sel_mid;
    logic [1:0]      sel_bot;
    logic [RW-1:0]   rows_out;

    logic            accept;
    logic            read_last;
    logic            frame_end;
    logic [3:0]      wr_en;
    logic [ROW_W-1:0] lb_rd [4];

    logic [WIN_W-1:0] win_nxt;
    logic            win_vld_nxt;
    logic            line_done_nxt;
    logic            frame_done_nxt;

    // Stall input when all four buffers are full or the whole frame is in.
    assign o_pixel_ready = !((fill == FW'(4 * IMG_W)) || (lines_in == LW'(IMG_H)));
    assign accept        = i_pixel_valid && o_pixel_ready;

    assign read_last = (state == READ) && (rd_col == CW'(IMG_W - 3));
    assign frame_end = read_last && (rows_out == RW'(IMG_H - 3));

    // Row completion frees one line; simultaneous accept and release net out.
    assign fill_nxt = fill + FW'(accept) - (read_last ? FW'(IMG_W) : FW'(0));

    assign sel_mid = rd_sel + 2'd1;
    assign sel_bot = rd_sel + 2'd2;

    // Four rotating line buffers; only the one selected by wr_sel is written.
    for (genvar i = 0; i < 4; i++) begin : g_lb
        assign wr_en[i] = accept && (wr_sel == 2'(i));

        line_buffer #(
            .IMG_W (IMG_W),
            .PIX_W (PIX_W)
        ) u_lb (
            .clk     (i_clk),
            .wr_en   (wr_en[i]),
            .wr_col  (wr_col),
            .wr_data (i_pixel),
            .rd_col  (rd_col),
            .rd_data (lb_rd[i])
        );
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: start a row once three lines are buffered.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if ((fill >= FW'(3 * IMG_W)) && (rows_out < RW'(IMG_H - 2))) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                if (rd_col == CW'(IMG_W - 3)) begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    // FSM outputs: window mux and pulse flags for the output register.
    always_comb begin
        win_nxt        = o_window;
        win_vld_nxt    = 1'b0;
        line_done_nxt  = 1'b0;
        frame_done_nxt = 1'b0;
        if (state == READ) begin
            win_nxt        = {lb_rd[sel_bot], lb_rd[sel_mid], lb_rd[rd_sel]};
            win_vld_nxt    = 1'b1;
            line_done_nxt  = read_last;
            frame_done_nxt = frame_end;
        end
    end

    // Output register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_window       <= '0;
            o_window_valid <= 1'b0;
            o_line_done    <= 1'b0;
            o_frame_done   <= 1'b0;
        end else begin
            o_window       <= win_nxt;
            o_window_valid <= win_vld_nxt;
            o_line_done    <= line_done_nxt;
            o_frame_done   <= frame_done_nxt;
        end
    end

    // Write/read counters. Frame end drops the two leftover lines so the next
    // frame starts from an empty, aligned buffer set.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_col   <= '0;
            wr_sel   <= '0;
            lines_in <= '0;
            fill     <= '0;
            rd_col   <= '0;
            rd_sel   <= '0;
            rows_out <= '0;
        end else if (frame_end) begin
            wr_col   <= '0;
            wr_sel   <= '0;
            lines_in <= '0;
            fill     <= '0;
            rd_col   <= '0;
            rd_sel   <= '0;
            rows_out <= '0;
        end else begin
            fill <= fill_nxt;
            if (accept) begin
                if (wr_col == CW'(IMG_W - 1)) begin
                    wr_col   <= '0;
                    wr_sel   <= wr_sel + 2'd1;
                    lines_in <= lines_in + LW'(1);
                end else begin
                    wr_col <= wr_col + CW'(1);
                end
            end
            if (state == READ) begin
                if (read_last) begin
                    rd_col   <= '0;
                    rd_sel   <= rd_sel + 2'd1;
                    rows_out <= rows_out + RW'(1);
                end else begin
                    rd_col <= rd_col + CW'(1);
                end
            end
        end
    end

endmodule
